// File: rtl/seg7_disp_sched.sv
// Round-robin scheduler sharing a 4-digit 7-segment display between four sources.
// Define SEG7_PREEMPT_EN to let source 0 (alarm) preempt any other owner.
module seg7_disp_sched #(
    parameter int unsigned HOLD_CYC = 25000000,
    parameter int unsigned TMR_W    = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [15:0] val0,
    input  logic [15:0] val1,
    input  logic [15:0] val2,
    input  logic [15:0] val3,
    output logic [3:0]  grant,
    output logic [3:0]  ack,
    output logic        busy,
    output logic [3:0]  digit3,
    output logic [3:0]  digit2,
    output logic [3:0]  digit1,
    output logic [3:0]  digit0
);

    typedef enum logic [0:0] {StIdle, StShow} state_e;

    localparam logic [TMR_W-1:0] TmrLast = TMR_W'(HOLD_CYC - 1);

    state_e           state_q;
    logic [1:0]       ptr_q;
    logic [TMR_W-1:0] tmr_q;

    logic [15:0] vals [4];
    logic [1:0]  win;
    logic        win_found;
    logic [15:0] win_val;
    logic [15:0] cur_val;

    assign vals[0] = val0;
    assign vals[1] = val1;
    assign vals[2] = val2;
    assign vals[3] = val3;

    // ptr_q is the current owner while showing, so one search serves idle, release and expiry.
    always_comb begin
        win       = ptr_q;
        win_found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            if (!win_found && req[ptr_q + 2'(i)]) begin
                win       = ptr_q + 2'(i);
                win_found = 1'b1;
            end
        end
    end

    assign win_val = vals[win];
    assign cur_val = vals[ptr_q];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            ptr_q   <= 2'd3;
            tmr_q   <= '0;
            grant   <= '0;
            ack     <= '0;
            busy    <= 1'b0;
            {digit3, digit2, digit1, digit0} <= 16'hFFFF;
        end else begin
            ack <= '0;
            case (state_q)
                StIdle: begin
                    if (win_found) begin
                        state_q <= StShow;
                        grant   <= 4'b0001 << win;
                        busy    <= 1'b1;
                        tmr_q   <= '0;
                        ptr_q   <= win;
                        {digit3, digit2, digit1, digit0} <= win_val;
                    end
                end
                StShow: begin
                    if (!req[ptr_q]) begin
                        tmr_q <= '0;
                        if (win_found) begin
                            grant <= 4'b0001 << win;
                            ptr_q <= win;
                            {digit3, digit2, digit1, digit0} <= win_val;
                        end else begin
                            state_q <= StIdle;
                            grant   <= '0;
                            busy    <= 1'b0;
                            {digit3, digit2, digit1, digit0} <= 16'hFFFF;
                        end
                    end
`ifdef SEG7_PREEMPT_EN
                    else if (ptr_q != 2'd0 && req[0]) begin
                        grant <= 4'b0001;
                        tmr_q <= '0;
                        ptr_q <= 2'd0;
                        {digit3, digit2, digit1, digit0} <= val0;
                    end
`endif
                    else if (tmr_q == TmrLast) begin
                        ack   <= 4'b0001 << ptr_q;
                        grant <= 4'b0001 << win;
                        tmr_q <= '0;
                        ptr_q <= win;
                        {digit3, digit2, digit1, digit0} <= win_val;
                    end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                        {digit3, digit2, digit1, digit0} <= cur_val;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_disp_sched.sv
// Bench for seg7_disp_sched: directed scenarios plus random requests against an owner/hold-count model.
module tb_seg7_disp_sched;

    localparam int HOLD = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req = '0;
    logic [15:0] v0 = '0, v1 = '0, v2 = '0, v3 = '0;
    logic [3:0]  grant, ack;
    logic        busy;
    logic [3:0]  digit3, digit2, digit1, digit0;

    int nvec = 0;
    int nerr = 0;

    // Reference model: who owns the display, how long it has held it, who held it last.
    int          owner = -1;
    int          held  = 0;
    int          last  = 3;
    logic [3:0]  e_grant = '0;
    logic [3:0]  e_ack   = '0;
    logic [15:0] e_dig   = 16'hFFFF;

    seg7_disp_sched #(.HOLD_CYC(HOLD), .TMR_W(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .val0   (v0),
        .val1   (v1),
        .val2   (v2),
        .val3   (v3),
        .grant  (grant),
        .ack    (ack),
        .busy   (busy),
        .digit3 (digit3),
        .digit2 (digit2),
        .digit1 (digit1),
        .digit0 (digit0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rr_pick(input int from, input logic [3:0] r);
        for (int k = 1; k <= 4; k++) begin
            if (r[(from + k) % 4]) return (from + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        owner   = -1;
        held    = 0;
        last    = 3;
        e_grant = '0;
        e_ack   = '0;
        e_dig   = 16'hFFFF;
    endtask

    task automatic model_step();
        logic [15:0] vv [4];
        vv = '{v0, v1, v2, v3};
        e_ack = '0;
        if (owner < 0) begin
            if (req != 0) begin
                owner = rr_pick(last, req);
                held  = 0;
            end
        end else if (!req[owner]) begin
            owner = (req != 0) ? rr_pick(owner, req) : -1;
            held  = 0;
        end
`ifdef SEG7_PREEMPT_EN
        else if (owner != 0 && req[0]) begin
            owner = 0;
            held  = 0;
        end
`endif
        else if (held == HOLD - 1) begin
            e_ack = 4'(1 << owner);
            owner = rr_pick(owner, req);
            held  = 0;
        end else begin
            held++;
        end
        if (owner >= 0) last = owner;
        e_grant = (owner < 0) ? 4'b0000 : 4'(1 << owner);
        e_dig   = (owner < 0) ? 16'hFFFF : vv[owner];
    endtask

    // Inputs are set by the caller away from the edge; outputs are sampled 1 time unit after it.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check("grant", {28'd0, grant}, {28'd0, e_grant});
        check("ack", {28'd0, ack}, {28'd0, e_ack});
        check("busy", {31'd0, busy}, {31'd0, |e_grant});
        check("digits", {16'd0, digit3, digit2, digit1, digit0}, {16'd0, e_dig});
    endtask

    initial begin
        // Reset state with no requests.
        repeat (3) @(posedge clk);
        #1;
        check("rst_grant", {28'd0, grant}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_digits", {16'd0, digit3, digit2, digit1, digit0}, 32'h0000FFFF);
        rst = 1'b1;
        model_reset();

        // Single requester: one-cycle grant latency, ack after the hold time.
        v1  = 16'h1234;
        req = 4'b0010;
        cycle();
        check("s1_grant", {28'd0, grant}, 32'h2);
        check("s1_digits", {16'd0, digit3, digit2, digit1, digit0}, 32'h1234);
        repeat (HOLD) cycle();
        check("s1_ack", {28'd0, ack}, 32'h2);
        req = 4'b0000;
        cycle();

        // All requesting: rotation, with a live value change during source 1.
        v0 = 16'hA0A0; v2 = 16'hC2C2; v3 = 16'hD3D3;
        req = 4'b1111;
        for (int c = 0; c < 5 * HOLD; c++) begin
            if (c == HOLD + 3) v1 = 16'h5678;
            cycle();
        end
        req = 4'b0000;
        cycle();

        // Early release with nothing pending, then with source 3 pending.
        req = 4'b0100;
        repeat (4) cycle();
        req = 4'b0000;
        cycle();
        check("rel_idle", {28'd0, grant}, 32'h0);
        req = 4'b0100;
        repeat (4) cycle();
        req = 4'b1000;
        cycle();
        check("rel_next", {28'd0, grant}, 32'h8);
        req = 4'b0000;
        cycle();

        // Alarm arriving while source 2 shows.
        req = 4'b0100;
        repeat (3) cycle();
        req = 4'b0101;
        repeat (3 * HOLD) cycle();
        req = 4'b0000;
        cycle();

        // Randomized requests and values.
        for (int c = 0; c < 800; c++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
            end
            if ($urandom_range(0, 3) == 0) v0 = 16'($urandom);
            if ($urandom_range(0, 3) == 0) v1 = 16'($urandom);
            if ($urandom_range(0, 3) == 0) v2 = 16'($urandom);
            if ($urandom_range(0, 3) == 0) v3 = 16'($urandom);
            cycle();
        end

        // Asynchronous reset in the middle of a grant.
        req = 4'b0010;
        repeat (3) cycle();
        #3;
        rst = 1'b0;
        #1;
        check("mid_rst_grant", {28'd0, grant}, 32'h0);
        check("mid_rst_ack", {28'd0, ack}, 32'h0);
        check("mid_rst_busy", {31'd0, busy}, 32'h0);
        check("mid_rst_digits", {16'd0, digit3, digit2, digit1, digit0}, 32'h0000FFFF);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        req = 4'b0001;
        cycle();
        check("post_rst_grant", {28'd0, grant}, 32'h1);
        repeat (HOLD + 2) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
